// File: rtl/adder_arb_pkg.sv
// -----------------------------------------------------------------------------
// adder_arb_pkg
// Shared types and constants for the shared-adder arbiter.
//   arb_state_t : sequencer states (IDLE -> EXEC -> RESP -> IDLE)
//   ARB_WIDTH   : default operand/sum width, matching the shared adder
// -----------------------------------------------------------------------------
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int ARB_WIDTH = 32;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin grant selection. The search begins at the
// requester after last_grant and wraps around, so the most recently served
// requester has the lowest priority.
// Ports:
//   req        in  NUM_REQ  request vector
//   last_grant in  ID_W     index of the most recently accepted requester
//   grant      out NUM_REQ  one-hot grant (all zero when no request)
//   grant_idx  out ID_W     encoded grant index
//   any_req    out 1        at least one request is pending
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               any_req
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    cand      = '0;
    // First hit wins; later candidates are masked by any_req.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!any_req && req[cand]) begin
        any_req     = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
// Shares one combinational adder between NUM_REQ requesters. One operand pair
// is accepted per transaction (IDLE), registered onto the adder inputs (EXEC),
// and the captured sum is presented with its requester ID until consumed
// (RESP).
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    in  NUM_REQ        per-requester operand pair valid
//   req_ready    out NUM_REQ        one-hot accept, only in IDLE
//   req_opA/B    in  NUM_REQ*WIDTH  packed operands, requester i at [i*WIDTH +: WIDTH]
//   adder_opA/B  out WIDTH          registered operands to the shared adder
//   adder_sum    in  WIDTH          combinational sum from the shared adder
//   rsp_valid    out 1              result valid (RESP)
//   rsp_id       out ID_W           owner of the result
//   rsp_data     out WIDTH          captured sum
//   rsp_ready    in  1              consumer accepts the result
// -----------------------------------------------------------------------------
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = ARB_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_opA,
  input  logic [NUM_REQ*WIDTH-1:0] req_opB,
  output logic [WIDTH-1:0]         adder_opA,
  output logic [WIDTH-1:0]         adder_opB,
  input  logic [WIDTH-1:0]         adder_sum,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  input  logic                     rsp_ready
);

  arb_state_t         state, state_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    last_grant;
  logic               any_req;
  logic               accept;
  logic [WIDTH-1:0]   sel_opA, sel_opB;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  assign accept  = (state == IDLE) && any_req;
  assign sel_opA = req_opA[int'(grant_idx)*WIDTH +: WIDTH];
  assign sel_opB = req_opB[int'(grant_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req)   state_next = EXEC;
      EXEC:                   state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = accept ? grant : '0;
    rsp_valid = (state == RESP);
  end

  // Accept stage: operands and owner latched onto the adder inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_opA  <= '0;
      adder_opB  <= '0;
      rsp_id     <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else if (accept) begin
      adder_opA  <= sel_opA;
      adder_opB  <= sel_opB;
      rsp_id     <= grant_idx;
      last_grant <= grant_idx;
    end
  end

  // Execute stage: sum from the shared adder held until the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              rsp_data <= '0;
    else if (state == EXEC)  rsp_data <= adder_sum;
  end

endmodule

// File: tb/tb_adder_arbiter.sv
module tb_adder_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_opA;
  logic [N*W-1:0] req_opB;
  logic [W-1:0]   adder_opA;
  logic [W-1:0]   adder_opB;
  logic [W-1:0]   adder_sum;
  logic           rsp_valid;
  logic [IW-1:0]  rsp_id;
  logic [W-1:0]   rsp_data;
  logic           rsp_ready;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [W-1:0]  data;
  } exp_t;
  exp_t sb[$];

  // Stand-in for the shared adder that sits beside the arbiter.
  assign adder_sum = adder_opA + adder_opB;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
    .adder_opA (adder_opA),
    .adder_opB (adder_opB),
    .adder_sum (adder_sum),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    req_opA[id*W +: W] = a;
    req_opB[id*W +: W] = b;
  endtask

  task automatic push(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.id   = IW'(id);
    e.data = a + b;
    sb.push_back(e);
  endtask

  task automatic expect_rsp(input string tag);
    exp_t e;
    chk({tag, "_rsp_valid"}, W'(rsp_valid), 1);
    chk({tag, "_sb_nonempty"}, W'(sb.size() != 0), 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rsp_id"}, W'(rsp_id), W'(e.id));
      chk({tag, "_rsp_data"}, rsp_data, e.data);
    end
  endtask

  // One transaction from an IDLE cycle with rsp_ready high; returns in IDLE.
  task automatic single(input string tag, input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    set_op(id, a, b);
    req_valid[id] = 1'b1;
    push(id, a, b);
    #1;
    chk({tag, "_grant"}, W'(req_ready), W'(32'(1) << id));
    tick();
    req_valid[id] = 1'b0;
    #1;
    chk({tag, "_opA"}, adder_opA, a);
    chk({tag, "_opB"}, adder_opB, b);
    chk({tag, "_exec_no_rsp"}, W'(rsp_valid), 0);
    chk({tag, "_exec_no_ready"}, W'(req_ready), 0);
    tick();
    #1;
    expect_rsp(tag);
    tick();
    #1;
    chk({tag, "_idle_no_rsp"}, W'(rsp_valid), 0);
  endtask

  initial begin
    int ngr;
    int last_t;

    rst_n     = 1'b0;
    req_valid = '0;
    req_opA   = '0;
    req_opB   = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    #1;
    chk("rst_req_ready", W'(req_ready), 0);
    chk("rst_rsp_valid", W'(rsp_valid), 0);
    chk("rst_rsp_id", W'(rsp_id), 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_opA", adder_opA, 0);
    chk("rst_opB", adder_opB, 0);
    rst_n = 1'b1;
    tick();

    single("basic", 0, 32'd1, 32'd3);
    single("wrap", 1, 32'hFFFF_FFFF, 32'h0000_0002);
    single("prep", 3, 32'd4, 32'd4);

    // Fairness: all requesters valid, last grant was 3.
    for (int i = 0; i < N; i++) set_op(i, W'(i), 32'd10);
    req_valid = '1;
    rsp_ready = 1'b1;
    ngr    = 0;
    last_t = 0;
    for (int c = 0; c < 15; c++) begin
      #1;
      chk("fair_onehot", W'($onehot0(req_ready)), 1);
      if (req_ready != '0) begin
        chk("fair_grant", W'(req_ready), W'(32'(1) << (ngr % N)));
        if (ngr > 0) chk("fair_gap", W'(c - last_t), 3);
        push(ngr % N, W'(ngr % N), 32'd10);
        last_t = c;
        ngr++;
      end
      if (rsp_valid) expect_rsp("fair");
      if (c == 14) req_valid = '0;
      tick();
    end
    chk("fair_count", W'(ngr), 5);
    chk("fair_drained", W'(sb.size()), 0);

    // Backpressure: requester 0 result held while requester 1 waits.
    rsp_ready = 1'b0;
    set_op(0, 32'd5, 32'd6);
    req_valid[0] = 1'b1;
    push(0, 32'd5, 32'd6);
    #1;
    chk("bp_grant0", W'(req_ready), 1);
    tick();
    req_valid[0] = 1'b0;
    set_op(1, 32'd7, 32'd8);
    req_valid[1] = 1'b1;
    #1;
    chk("bp_exec_no_ready", W'(req_ready), 0);
    tick();
    #1;
    expect_rsp("bp");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        tick();
        #1;
      end
      chk("bp_hold_valid", W'(rsp_valid), 1);
      chk("bp_hold_data", rsp_data, 32'd11);
      chk("bp_hold_id", W'(rsp_id), 0);
      chk("bp_hold_no_ready", W'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("bp_grant1", W'(req_ready), 2);
    chk("bp_idle_no_rsp", W'(rsp_valid), 0);
    push(1, 32'd7, 32'd8);
    tick();
    req_valid[1] = 1'b0;
    tick();
    #1;
    expect_rsp("bp2");
    tick();

    // Reset during EXEC.
    set_op(2, 32'd100, 32'd1);
    req_valid[2] = 1'b1;
    push(2, 32'd100, 32'd1);
    #1;
    chk("rm_grant2", W'(req_ready), 4);
    tick();
    req_valid[2] = 1'b0;
    #1;
    chk("rm_exec_opA", adder_opA, 32'd100);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_rsp_valid", W'(rsp_valid), 0);
    chk("rm_req_ready", W'(req_ready), 0);
    chk("rm_opA", adder_opA, 0);
    chk("rm_opB", adder_opB, 0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rm_no_stale", W'(rsp_valid), 0);
      tick();
    end
    set_op(0, 32'd20, 32'd22);
    set_op(3, 32'd1, 32'd1);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    push(0, 32'd20, 32'd22);
    #1;
    chk("rm_prio0", W'(req_ready), 1);
    tick();
    req_valid = '0;
    tick();
    #1;
    expect_rsp("rm");
    tick();

    // Requester 2 appears during RESP and leaves before IDLE.
    rsp_ready = 1'b0;
    set_op(1, 32'd3, 32'd4);
    req_valid[1] = 1'b1;
    push(1, 32'd3, 32'd4);
    #1;
    chk("drop_grant1", W'(req_ready), 2);
    tick();
    req_valid[1] = 1'b0;
    tick();
    #1;
    expect_rsp("drop");
    set_op(2, 32'd9, 32'd9);
    req_valid[2] = 1'b1;
    tick();
    #1;
    chk("drop_resp_no_ready", W'(req_ready), 0);
    req_valid[2] = 1'b0;
    rsp_ready = 1'b1;
    tick();
    #1;
    chk("drop_idle_no_ready", W'(req_ready), 0);
    chk("drop_idle_no_rsp", W'(rsp_valid), 0);
    tick();
    #1;
    chk("drop_stay_no_ready", W'(req_ready), 0);
    chk("drop_stay_no_rsp", W'(rsp_valid), 0);
    chk("drop_opA_kept", adder_opA, 32'd3);
    chk("final_sb_empty", W'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares the single 32-bit combinational `adder` datapath between up to NUM_REQ filter-stage requesters. It accepts one operand pair at a time with a valid/ready handshake, registers the operands into the shared adder, captures the sum, and returns it with the requester ID. It sits between the filter tap units and the one `adder` instance, so the filter processor needs only one physical 32-bit adder.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 32, operand and sum width; matches `adder`
- `ID_W`, $clog2(NUM_REQ), requester-ID width

Ports:
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NUM_REQ  per-requester operand pair valid
- `req_ready`  out  NUM_REQ  one-hot; operand pair accepted this cycle
- `req_opA`  in  NUM_REQ*WIDTH  packed operand A; requester i uses bits [i*WIDTH +: WIDTH]
- `req_opB`  in  NUM_REQ*WIDTH  packed operand B, same packing
- `adder_opA`  out  WIDTH  registered operand A to shared `adder`
- `adder_opB`  out  WIDTH  registered operand B to shared `adder`
- `adder_sum`  in  WIDTH  combinational sum from shared `adder`
- `rsp_valid`  out  1  result valid
- `rsp_id`  out  ID_W  index of the requester that owns the result
- `rsp_data`  out  WIDTH  sum result
- `rsp_ready`  in  1  consumer accepts the result

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `req_valid` is high, the round-robin arbiter picks grant g.
  - `req_ready[g]=1` combinationally in the same cycle.
  - At the clock edge: operands of g go into `adder_opA`/`adder_opB`, g goes into the ID register, and the FSM moves to EXEC.
  - With no requests, the FSM stays in IDLE and `req_ready=0`.
- EXEC: at the clock edge, `adder_sum` is captured into `rsp_data` and the FSM moves to RESP. `req_ready=0`.
- RESP:
  - `rsp_valid=1`. `rsp_data` and `rsp_id` stay stable.
  - If `rsp_ready=1`, the FSM returns to IDLE at the clock edge. Otherwise it holds RESP with no timeout.
  - `req_ready=0` throughout.
- Round-robin priority:
  - Search starts at (last_grant+1) mod NUM_REQ and wraps.
  - last_grant updates only on acceptance.
  - At reset, last_grant=NUM_REQ-1, so requester 0 has highest priority.
- Arithmetic: sum is modulo 2^WIDTH. Carry-out is discarded, as in `adder`.
- Requester rules: a requester must hold `req_valid` and its operands stable until `req_ready`. Dropping `req_valid` before acceptance is legal; the arbiter then ignores that requester.
- `req_ready` is never asserted outside IDLE and is never multi-hot.

## Timing
- Accept edge at cycle 0 → `adder_opA/B` valid in cycle 1 (EXEC) → `rsp_valid` high in cycle 2.
- Latency from acceptance to `rsp_valid` is 2 cycles.
- Minimum issue interval is 3 cycles, reached when `rsp_ready` is held high.
- Reset values: state=IDLE, `req_ready=0`, `rsp_valid=0`, `rsp_id=0`, `rsp_data=0`, `adder_opA=0`, `adder_opB=0`, last_grant=NUM_REQ-1.
- Reset asserted mid-operation: the in-flight transaction is discarded and all outputs return to reset values immediately (asynchronous). No response is produced after reset deasserts.
- A `req_valid` that rises while the FSM is in EXEC or RESP waits for the next IDLE cycle.
- Simultaneous `rsp_ready` handshake and new `req_valid`: the FSM enters IDLE first, so the new request is accepted one cycle later. There is no bypass.

## Structure
- Package `adder_arb_pkg`:
  - state enum `arb_state_t` {IDLE, EXEC, RESP}
  - default `WIDTH` constant (32)
- Sub-module `rr_arbiter`:
  - parameter NUM_REQ
  - inputs: req vector, last_grant
  - outputs: one-hot grant, encoded grant index, any_req
  - purely combinational
- The top level instantiates `rr_arbiter` plus the FSM and registers. The shared `adder` is instantiated beside this block, not inside it.

## Test plan
- Single request: requester 0 sends opA=1, opB=3 with `rsp_ready` high. Required: `req_ready[0]` in cycle 0, `rsp_valid` in cycle 2 with `rsp_data`=4 and `rsp_id`=0.
- Wrap-around: opA=0xFFFFFFFF, opB=0x00000002. Required: `rsp_data`=0x00000001, with no extra outputs or flags.
- Fairness: all four requesters valid continuously, each with opA=i, opB=10. Required: grants in order 0,1,2,3,0, 3 cycles apart, with `rsp_data` 10,11,12,13,10.
- Backpressure: `rsp_ready` held low for 5 cycles in RESP while requester 1 is valid. Required: `rsp_valid`, `rsp_data` and `rsp_id` stable; `req_ready` stays 0; requester 1 is accepted in the first IDLE cycle after the handshake.
- Reset mid-op: `rst_n` pulled low during EXEC. Required: `rsp_valid`, `req_ready`, `adder_opA` and `adder_opB` go to 0 immediately; after release, no stale response appears and requester 0 has priority.
- Drop-before-accept: requester 2 raises `req_valid` during RESP, then drops it before IDLE. Required: no grant to requester 2 and the FSM stays in IDLE.
